// File: rtl/regfile_wr_arbiter.sv
// Two-requester round-robin arbiter feeding a register-file write port through
// a one-entry output register; counts issued nonzero-address writes.
module regfile_wr_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             hold,
  input  logic             req0_valid,
  input  logic [4:0]       req0_addr,
  input  logic [31:0]      req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [4:0]       req1_addr,
  input  logic [31:0]      req1_data,
  output logic             req1_ready,
  output logic             we3,
  output logic [4:0]       wa3,
  output logic [31:0]      wd3,
  output logic             pend_valid,
  output logic             gnt_id,
  output logic [CNT_W-1:0] wr_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t      state, state_next;
  logic        last_gnt;
  logic        win0, win1;
  logic        hs;
  logic [4:0]  acc_addr;
  logic [31:0] acc_data;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
    // Contended cycles go to whichever requester was not granted last.
    if (req0_valid && (!req1_valid || last_gnt)) win0 = 1'b1;
    else if (req1_valid)                         win1 = 1'b1;
  end

  assign req0_ready = reset_n && !hold && win0;
  assign req1_ready = reset_n && !hold && win1;
  assign hs         = req0_ready || req1_ready;
  assign acc_addr   = req1_ready ? req1_addr : req0_addr;
  assign acc_data   = req1_ready ? req1_data : req0_data;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (hs)  state_next = WRITE;
      WRITE:   if (!hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the processes are evaluated in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: all datapath registers are reset here (there is no large storage
  // array), so the presented write is well defined from the first cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wa3      <= '0;
      wd3      <= '0;
      gnt_id   <= 1'b0;
      last_gnt <= 1'b1;
      wr_count <= '0;
    end else if (hs) begin
      wa3      <= acc_addr;
      wd3      <= acc_data;
      gnt_id   <= req1_ready;
      last_gnt <= req1_ready;
      if ((acc_addr != 5'd0) && (wr_count != {CNT_W{1'b1}}))
        wr_count <= wr_count + CNT_W'(1);
    end
  end

  assign pend_valid = (state == WRITE);
  // Register 0 is hardwired; its writes take the slot but never strobe we3.
  assign we3        = pend_valid && (wa3 != 5'd0);

endmodule
